// File: rtl/subtrator_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// FSM state encoding and counter width helper.
package subtrator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter width for a WIDTH-bit operand: $clog2(WIDTH), never below 1.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/subtrator_bit_cell.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Ports: a, b, bin (in); d, bout (out). Purely combinational.
module subtrator_bit_cell
  import subtrator_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, start/busy/done.
// Ports: clk, rst, start, a, b -> busy, done, diff, borrow_out[, ovf if SUBTRATOR_OVERFLOW_EN].
module subtrator_serial
  import subtrator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUBTRATOR_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             d_bit, bo_bit;

  subtrator_bit_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (bo_bit)
  );

`ifdef SUBTRATOR_OVERFLOW_EN
  // Operand MSBs are kept apart because a_q/b_q are shifted away.
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
`ifdef SUBTRATOR_OVERFLOW_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          b_d     = b;
          diff_d  = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          bo_d    = 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
          am_d    = a[WIDTH-1];
          bm_d    = b[WIDTH-1];
          ovf_d   = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        br_d   = bo_bit;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          bo_d    = bo_bit;
`ifdef SUBTRATOR_OVERFLOW_EN
          // On the last edge d_bit is the result MSB.
          ovf_d   = (am_q ^ bm_q) & (am_q ^ d_bit);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
`ifdef SUBTRATOR_OVERFLOW_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
`ifdef SUBTRATOR_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed bench for subtrator_serial (WIDTH=8).
// Handshake timing, results, start-ignore, reset abort, back-to-back.
module tb_subtrator_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SUBTRATOR_OVERFLOW_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  subtrator_serial #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SUBTRATOR_OVERFLOW_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] av,
                        input logic [7:0] bv,
                        input logic [7:0] exp_d,
                        input logic exp_bo,
                        input logic exp_ovf);
    int   lat;
    int   bcnt;
    logic midbo;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    lat   = 0;
    bcnt  = 0;
    midbo = 1'b0;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      if (borrow_out) midbo = 1'b1;
      tick();
      lat++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, lat, 32'd8);
    check({tag, "_busy"}, bcnt, 32'd8);
    check({tag, "_midbo"}, 32'(midbo), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check({tag, "_bo"}, 32'(borrow_out), 32'(exp_bo));
    tick();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(diff), 32'(exp_d));
`ifdef SUBTRATOR_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) check({tag, "_ovfx"}, 32'd0, 32'd1);
`endif
  endtask

  initial begin
    int   ndone;
    int   ts [3];
    logic [7:0] dcap;
    logic dbad;

    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bo", 32'(borrow_out), 32'd0);
`ifdef SUBTRATOR_OVERFLOW_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();

    run_op("t1", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    run_op("t2a", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    run_op("t2b", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

    // start pulsed mid-SHIFT must be ignored
    a     = 8'h35;
    b     = 8'h12;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    dcap  = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        ndone++;
        dcap = diff;
      end
    end
    check("t3_ndone", ndone, 32'd1);
    check("t3_diff", 32'(dcap), 32'h23);

    // reset abort after four SHIFT edges
    a     = 8'h35;
    b     = 8'h12;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t4_partial", 32'(diff), 32'h30);
    rst = 1'b1;
    tick();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_diff", 32'(diff), 32'd0);
    check("t4_bo", 32'(borrow_out), 32'd0);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("t4_nodone", ndone, 32'd0);
    run_op("t4_new", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);

    // start held high: a result every WIDTH+2 cycles
    a     = 8'hA0;
    b     = 8'h0A;
    start = 1'b1;
    tick();
    ndone = 0;
    dbad  = 1'b0;
    ts[0] = -1;
    ts[1] = -1;
    ts[2] = -1;
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (done) begin
        if (ndone < 3) ts[ndone] = i;
        ndone++;
        if (diff !== 8'h96) dbad = 1'b1;
      end
    end
    start = 1'b0;
    check("t5_ndone", ndone, 32'd3);
    check("t5_first", ts[0], 32'd8);
    check("t5_gap1", ts[1] - ts[0], 32'd10);
    check("t5_gap2", ts[2] - ts[1], 32'd10);
    check("t5_diff", 32'(dbad), 32'd0);
    for (int i = 0; i < 12; i++) tick();

    run_op("t6a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("t6b", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
